register_file_sb: RTL and testbench

- Parametrised successor of the two-read/one-write pipeline register file.
- Provides READ_PORTS combinational read ports, one synchronous write port, and write-to-read bypass.
- Register 0 is hardwired to zero.
- An integrated busy scoreboard tracks registers with an outstanding multi-cycle writeback. The issue stage uses it for hazard stalls.

---
 rtl/register_file_sb_pkg.sv | 9 +
 rtl/register_file_sb_if.sv | 27 ++
 rtl/register_file_sb_scoreboard.sv | 46 ++++
 rtl/register_file_sb.sv | 45 ++++
 tb/tb_register_file_sb.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/register_file_sb_pkg.sv
// register_file_sb_pkg: shared constants and width helper for the register file slice
package register_file_sb_pkg;
    localparam int DATA_W = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG = 0;
    function automatic int count_w(input int addr_w);
        return addr_w + 1;
    endfunction
endpackage

// File: rtl/register_file_sb_if.sv
// register_file_sb_if: write, read, scoreboard and issue signals of the register file
interface register_file_sb_if
    import register_file_sb_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int READ_PORTS = 2
);
    logic                         Reg_Write_i;
    logic [ADDR_W-1:0]            Write_Register_i;
    logic [N-1:0]                 Write_Data_i;
    logic [READ_PORTS*ADDR_W-1:0] Read_Register_i;
    logic [READ_PORTS*N-1:0]      Read_Data_o;
    logic [READ_PORTS-1:0]        Busy_o;
    logic                         Issue_Valid_i;
    logic [ADDR_W-1:0]            Issue_Register_i;
    logic                         Issue_Ready_o;
    logic [count_w(ADDR_W)-1:0]   Pending_Count_o;
    modport master (
        output Reg_Write_i, Write_Register_i, Write_Data_i, Read_Register_i, Issue_Valid_i, Issue_Register_i,
        input  Read_Data_o, Busy_o, Issue_Ready_o, Pending_Count_o
    );
    modport slave (
        input  Reg_Write_i, Write_Register_i, Write_Data_i, Read_Register_i, Issue_Valid_i, Issue_Register_i,
        output Read_Data_o, Busy_o, Issue_Ready_o, Pending_Count_o
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// register_scoreboard: busy bits for outstanding writebacks, issue-ready and pending count
module register_scoreboard
    import register_file_sb_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int READ_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_wr_en,
    input  logic [ADDR_W-1:0]            i_wr_addr,
    input  logic                         i_iss_valid,
    input  logic [ADDR_W-1:0]            i_iss_addr,
    input  logic [READ_PORTS*ADDR_W-1:0] i_rd_addr,
    output logic [READ_PORTS-1:0]        o_busy,
    output logic                         o_iss_ready,
    output logic [count_w(ADDR_W)-1:0]   o_pending
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CW = count_w(ADDR_W);
    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CW-1:0]    r_count;
    logic             w_set;
    logic             w_clr;
    // a writeback landing this cycle frees the register in time for a new issue
    assign o_iss_ready = rst_n && (!r_busy[i_iss_addr] || (i_wr_en && i_wr_addr == i_iss_addr));
    assign w_set = i_iss_valid && o_iss_ready && i_iss_addr != ADDR_W'(ZERO_REG);
    assign w_clr = i_wr_en && r_busy[i_wr_addr];
    assign w_busy_nxt = (r_busy & ~(DEPTH'(w_clr) << i_wr_addr)) | (DEPTH'(w_set) << i_iss_addr);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= r_count + CW'(w_set) - CW'(w_clr);
        end
    end
    assign o_pending = r_count;
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_busy
        logic [ADDR_W-1:0] w_ra;
        assign w_ra = i_rd_addr[k*ADDR_W +: ADDR_W];
        assign o_busy[k] = rst_n && r_busy[w_ra] && !(i_wr_en && i_wr_addr == w_ra);
    end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with zero register, write bypass and busy scoreboard
module register_file_sb
    import register_file_sb_pkg::*;
#(
    parameter int N = DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int READ_PORTS = 2,
    parameter int BYPASS = 1
) (
    input logic               clk,
    input logic               reset,
    register_file_sb_if.slave io_bus
);
    localparam int DEPTH = 2**ADDR_W;
    logic [N-1:0] r_regs [DEPTH];
    logic         w_wr;
    assign w_wr = io_bus.Reg_Write_i && io_bus.Write_Register_i != ADDR_W'(ZERO_REG);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[io_bus.Write_Register_i] <= io_bus.Write_Data_i;
        end
    end
    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic              w_fwd;
        assign w_ra  = io_bus.Read_Register_i[k*ADDR_W +: ADDR_W];
        assign w_fwd = (BYPASS != 0) && io_bus.Reg_Write_i && io_bus.Write_Register_i == w_ra;
        assign io_bus.Read_Data_o[k*N +: N] = (!reset || w_ra == ADDR_W'(ZERO_REG)) ? '0 :
                                              w_fwd ? io_bus.Write_Data_i : r_regs[w_ra];
    end
    register_scoreboard #(.ADDR_W(ADDR_W), .READ_PORTS(READ_PORTS)) u_sb (
        .clk         (clk),
        .rst_n       (reset),
        .i_wr_en     (io_bus.Reg_Write_i),
        .i_wr_addr   (io_bus.Write_Register_i),
        .i_iss_valid (io_bus.Issue_Valid_i),
        .i_iss_addr  (io_bus.Issue_Register_i),
        .i_rd_addr   (io_bus.Read_Register_i),
        .o_busy      (io_bus.Busy_o),
        .o_iss_ready (io_bus.Issue_Ready_o),
        .o_pending   (io_bus.Pending_Count_o)
    );
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: directed table, corner sequences and random traffic against a register/busy-set model
module tb_register_file_sb;
    logic clk = 0;
    logic reset = 0;
    int passed = 0;
    int total = 0;
    logic [31:0] m_regs [32];
    bit m_busy [32];
    always #5 clk = ~clk;
    register_file_sb_if #(.N(32), .ADDR_W(5), .READ_PORTS(2)) b1 ();
    register_file_sb_if #(.N(32), .ADDR_W(5), .READ_PORTS(2)) b0 ();
    assign b0.Reg_Write_i      = b1.Reg_Write_i;
    assign b0.Write_Register_i = b1.Write_Register_i;
    assign b0.Write_Data_i     = b1.Write_Data_i;
    assign b0.Read_Register_i  = b1.Read_Register_i;
    assign b0.Issue_Valid_i    = b1.Issue_Valid_i;
    assign b0.Issue_Register_i = b1.Issue_Register_i;
    register_file_sb #(.N(32), .ADDR_W(5), .READ_PORTS(2), .BYPASS(1)) dut1 (.clk(clk), .reset(reset), .io_bus(b1));
    register_file_sb #(.N(32), .ADDR_W(5), .READ_PORTS(2), .BYPASS(0)) dut0 (.clk(clk), .reset(reset), .io_bus(b0));

    typedef struct {
        logic we; logic [4:0] wa; logic [31:0] wd; logic [4:0] r0; logic [4:0] r1; logic iv; logic [4:0] ia;
        logic [31:0] e0; logic [31:0] e1; logic [31:0] enb1; logic [1:0] ebusy; logic erdy; logic [5:0] ecnt;
    } vec_t;
    vec_t tbl [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r0, input logic [4:0] r1, input logic iv, input logic [4:0] ia);
        b1.Reg_Write_i = we;
        b1.Write_Register_i = wa;
        b1.Write_Data_i = wd;
        b1.Read_Register_i = {r1, r0};
        b1.Issue_Valid_i = iv;
        b1.Issue_Register_i = ia;
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] ra, input bit byp);
        if (ra == 0) return 0;
        if (byp && b1.Reg_Write_i && b1.Write_Register_i == ra) return b1.Write_Data_i;
        return m_regs[ra];
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_ready();
        return !m_busy[b1.Issue_Register_i] || (b1.Reg_Write_i && b1.Write_Register_i == b1.Issue_Register_i);
    endfunction

    task automatic apply_model();
        bit rdy = m_ready();
        if (b1.Reg_Write_i && b1.Write_Register_i != 0) m_regs[b1.Write_Register_i] = b1.Write_Data_i;
        if (b1.Reg_Write_i) m_busy[b1.Write_Register_i] = 0;
        if (b1.Issue_Valid_i && rdy && b1.Issue_Register_i != 0) m_busy[b1.Issue_Register_i] = 1;
    endtask

    task automatic advance();
        apply_model();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
    endtask

    task automatic check_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [4:0] ra = b1.Read_Register_i[k*5 +: 5];
            chk($sformatf("%s_rd%0d", tag, k), b1.Read_Data_o[k*32 +: 32], m_rd(ra, 1));
            chk($sformatf("%s_nb_rd%0d", tag, k), b0.Read_Data_o[k*32 +: 32], m_rd(ra, 0));
            chk($sformatf("%s_busy%0d", tag, k), b1.Busy_o[k],
                m_busy[ra] && !(b1.Reg_Write_i && b1.Write_Register_i == ra));
        end
        chk({tag, "_ready"}, b1.Issue_Ready_o, m_ready());
        chk({tag, "_count"}, b1.Pending_Count_o, m_cnt());
    endtask

    task automatic check_cleared(input string tag, input logic rdy);
        chk({tag, "_rd"}, b1.Read_Data_o, 0);
        chk({tag, "_nb_rd"}, b0.Read_Data_o, 0);
        chk({tag, "_busy"}, b1.Busy_o, 0);
        chk({tag, "_count"}, b1.Pending_Count_o, 0);
        chk({tag, "_ready"}, b1.Issue_Ready_o, rdy);
    endtask

    initial begin
        tbl[0]  = '{1, 2, 7, 2, 31, 0, 0, 7, 0, 0, 0, 1, 0};
        tbl[1]  = '{1, 4, 20, 2, 31, 0, 0, 7, 0, 0, 0, 1, 0};
        tbl[2]  = '{1, 31, 78, 2, 31, 0, 0, 7, 78, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 5, 0, 31, 0, 0, 0, 78, 78, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 2, 31, 0, 0, 7, 78, 78, 0, 1, 0};
        tbl[5]  = '{1, 25, 6, 4, 25, 0, 0, 20, 6, 0, 0, 1, 0};
        tbl[6]  = '{1, 25, 'hDEAD, 0, 25, 0, 0, 0, 'hDEAD, 6, 0, 1, 0};
        tbl[7]  = '{0, 0, 0, 25, 25, 0, 0, 'hDEAD, 'hDEAD, 'hDEAD, 0, 1, 0};
        tbl[8]  = '{0, 0, 0, 4, 2, 1, 4, 20, 7, 7, 0, 1, 0};
        tbl[9]  = '{0, 0, 0, 4, 2, 1, 4, 20, 7, 7, 1, 0, 1};
        tbl[10] = '{1, 4, 21, 4, 4, 0, 0, 21, 21, 20, 0, 1, 1};
        tbl[11] = '{0, 0, 0, 4, 4, 0, 0, 21, 21, 21, 0, 1, 0};
        tbl[12] = '{0, 0, 0, 4, 4, 1, 4, 21, 21, 21, 0, 1, 0};
        tbl[13] = '{1, 4, 9, 4, 4, 1, 4, 9, 9, 21, 0, 1, 1};
        tbl[14] = '{0, 0, 0, 4, 0, 1, 0, 9, 0, 0, 1, 1, 1};
        tbl[15] = '{0, 0, 0, 4, 0, 0, 0, 9, 0, 0, 1, 1, 1};
        tbl[16] = '{1, 4, 9, 4, 0, 0, 0, 9, 0, 0, 0, 1, 1};
        tbl[17] = '{0, 0, 0, 4, 0, 0, 0, 9, 0, 0, 0, 1, 0};
        model_reset();
        // writes and issues while reset is held low must leave no trace
        set_in(1, 2, 3, 2, 2, 1, 3);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_cleared("in_reset", 0);
        set_in(0, 0, 0, 2, 2, 0, 5);
        #2 reset = 1;
        #1;
        check_cleared("post_reset", 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r0, tbl[i].r1, tbl[i].iv, tbl[i].ia);
            #2;
            chk($sformatf("v%0d_rd0", i), b1.Read_Data_o[31:0], tbl[i].e0);
            chk($sformatf("v%0d_rd1", i), b1.Read_Data_o[63:32], tbl[i].e1);
            chk($sformatf("v%0d_nb_rd1", i), b0.Read_Data_o[63:32], tbl[i].enb1);
            chk($sformatf("v%0d_busy", i), b1.Busy_o, tbl[i].ebusy);
            chk($sformatf("v%0d_ready", i), b1.Issue_Ready_o, tbl[i].erdy);
            chk($sformatf("v%0d_count", i), b1.Pending_Count_o, tbl[i].ecnt);
            advance();
        end
        set_in(0, 0, 0, 2, 25, 1, 2);
        advance();
        set_in(0, 0, 0, 2, 25, 1, 4);
        advance();
        set_in(0, 0, 0, 2, 25, 1, 25);
        advance();
        set_in(0, 0, 0, 2, 25, 0, 0);
        #1;
        chk("mid_pre_count", b1.Pending_Count_o, 3);
        chk("mid_pre_busy", b1.Busy_o, 2'b11);
        chk("mid_pre_rd1", b1.Read_Data_o[63:32], 'hDEAD);
        #1 reset = 0;
        #1;
        check_cleared("mid_low", 0);
        reset = 1;
        model_reset();
        #1;
        check_cleared("mid_after", 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a [4];
            for (int j = 0; j < 4; j++) a[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            set_in(1'($urandom), a[0], $urandom, a[1], a[2], 1'($urandom), a[3]);
            #2;
            check_model($sformatf("rnd%0d", i));
            advance();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
